// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: arbiter FSM encoding and the cache line width.
package rv32i_types;

    localparam int CACHE_LINE_WIDTH = 256;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RECOVER = 2'd3
    } arb_state_t;

endpackage

// File: rtl/cache_arbiter.sv
// Shares one memory line port between the I-cache and D-cache, granting each
// miss whole and alternating ties through last_d_r so neither side starves.
module cache_arbiter
    import rv32i_types::*;
#(
    parameter int LINE_WIDTH = CACHE_LINE_WIDTH,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_pmem_read,
    input  logic [ADDR_WIDTH-1:0] i_pmem_address,
    output logic [LINE_WIDTH-1:0] i_pmem_rdata,
    output logic                  i_pmem_resp,
    input  logic                  d_pmem_read,
    input  logic                  d_pmem_write,
    input  logic [ADDR_WIDTH-1:0] d_pmem_address,
    input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
    output logic [LINE_WIDTH-1:0] d_pmem_rdata,
    output logic                  d_pmem_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    arb_state_t state_r;
    arb_state_t next_state_s;
    logic       last_d_r;
    logic       next_last_d_s;
    logic       i_req_s;
    logic       d_req_s;

    assign i_req_s      = i_pmem_read;
    assign d_req_s      = d_pmem_read | d_pmem_write;
    assign i_pmem_rdata = pmem_rdata;
    assign d_pmem_rdata = pmem_rdata;

    // State and tie-break history registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= IDLE;
            last_d_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            last_d_r <= next_last_d_s;
        end
    end

    // Next-state selection; a grant is held until the memory responds.
    always_comb begin
        next_state_s  = state_r;
        next_last_d_s = last_d_r;
        case (state_r)
            IDLE: begin
                if (i_req_s && d_req_s) begin
                    next_state_s = last_d_r ? SERVE_I : SERVE_D;
                end else if (i_req_s) begin
                    next_state_s = SERVE_I;
                end else if (d_req_s) begin
                    next_state_s = SERVE_D;
                end else begin
                    next_state_s = IDLE;
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    next_state_s  = RECOVER;
                    next_last_d_s = 1'b0;
                end else begin
                    next_state_s = SERVE_I;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    next_state_s  = RECOVER;
                    next_last_d_s = 1'b1;
                end else begin
                    next_state_s = SERVE_D;
                end
            end
            RECOVER: begin
                // Dead cycle lets the served cache drop its request first.
                next_state_s = IDLE;
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Memory-port mux: only the granted side sees strobes and responses.
    always_comb begin
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        pmem_address = {ADDR_WIDTH{1'b0}};
        pmem_wdata   = {LINE_WIDTH{1'b0}};
        i_pmem_resp  = 1'b0;
        d_pmem_resp  = 1'b0;
        case (state_r)
            SERVE_I: begin
                pmem_read    = i_pmem_read;
                pmem_address = i_pmem_address;
                i_pmem_resp  = pmem_resp;
            end
            SERVE_D: begin
                pmem_read    = d_pmem_read;
                pmem_write   = d_pmem_write;
                pmem_address = d_pmem_address;
                pmem_wdata   = d_pmem_wdata;
                d_pmem_resp  = pmem_resp;
            end
            IDLE: begin
                pmem_read = 1'b0;
            end
            RECOVER: begin
                pmem_read = 1'b0;
            end
            default: begin
                pmem_read = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_arbiter.sv
// Scoreboard bench for cache_arbiter: expected grants are queued as requests
// are raised and popped when the memory strobe appears.
module tb_cache_arbiter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         i_pmem_read = 1'b0;
    logic [31:0]  i_pmem_address = 32'h0;
    logic [255:0] i_pmem_rdata;
    logic         i_pmem_resp;
    logic         d_pmem_read = 1'b0;
    logic         d_pmem_write = 1'b0;
    logic [31:0]  d_pmem_address = 32'h0;
    logic [255:0] d_pmem_wdata = 256'h0;
    logic [255:0] d_pmem_rdata;
    logic         d_pmem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [31:0]  pmem_address;
    logic [255:0] pmem_wdata;
    logic [255:0] pmem_rdata = 256'h0;
    logic         pmem_resp = 1'b0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         rd;
        logic         wr;
        logic [31:0]  addr;
        logic [255:0] wdata;
    } grant_t;

    grant_t exp_q[$];

    cache_arbiter #(.LINE_WIDTH(256), .ADDR_WIDTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .i_pmem_read    (i_pmem_read),
        .i_pmem_address (i_pmem_address),
        .i_pmem_rdata   (i_pmem_rdata),
        .i_pmem_resp    (i_pmem_resp),
        .d_pmem_read    (d_pmem_read),
        .d_pmem_write   (d_pmem_write),
        .d_pmem_address (d_pmem_address),
        .d_pmem_wdata   (d_pmem_wdata),
        .d_pmem_rdata   (d_pmem_rdata),
        .d_pmem_resp    (d_pmem_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_grant(input logic rd, input logic wr, input logic [31:0] addr,
                              input logic [255:0] wdata);
        grant_t g;
        g.rd = rd; g.wr = wr; g.addr = addr; g.wdata = wdata;
        exp_q.push_back(g);
    endtask

    task automatic wait_strobe(output int cycles, input string tag);
        cycles = 0;
        while ((pmem_read | pmem_write) !== 1'b1 && cycles < 64) begin
            tick();
            cycles++;
        end
        if (cycles >= 64) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: no memory strobe within %0d cycles", tag, cycles);
        end
    endtask

    task automatic check_grant(input string tag);
        grant_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s_sb: strobe seen but scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            if ({pmem_read, pmem_write} !== {e.rd, e.wr}) begin
                errors++;
                $display("FAIL %s_strobe: got rd/wr %b%b expected %b%b", tag,
                         pmem_read, pmem_write, e.rd, e.wr);
            end
            checks++;
            if (pmem_address !== e.addr) begin
                errors++;
                $display("FAIL %s_addr: got %h expected %h", tag, pmem_address, e.addr);
            end
            checks++;
            if (pmem_wdata !== e.wdata) begin
                errors++;
                $display("FAIL %s_wdata: got %h expected %h", tag, pmem_wdata, e.wdata);
            end
        end
    endtask

    // Memory answers after 'delay' cycles, then the served side drops its request.
    task automatic respond(input logic is_d, input int delay, input logic [255:0] data,
                           input string tag);
        logic [1:0]   exp_resp;
        logic [255:0] got_data;
        exp_resp = is_d ? 2'b01 : 2'b10;
        for (int k = 0; k < delay; k++) begin
            checks++;
            if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
                errors++;
                $display("FAIL %s_early_resp: got i/d %b%b expected 00", tag,
                         i_pmem_resp, d_pmem_resp);
            end
            tick();
        end
        pmem_rdata = data;
        pmem_resp  = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== exp_resp) begin
            errors++;
            $display("FAIL %s_resp: got i/d %b%b expected %b", tag, i_pmem_resp,
                     d_pmem_resp, exp_resp);
        end
        got_data = is_d ? d_pmem_rdata : i_pmem_rdata;
        checks++;
        if (got_data !== data) begin
            errors++;
            $display("FAIL %s_rdata: got %h expected %h", tag, got_data, data);
        end
        tick();
        pmem_resp = 1'b0;
        if (is_d) begin
            d_pmem_read  = 1'b0;
            d_pmem_write = 1'b0;
        end else begin
            i_pmem_read = 1'b0;
        end
        #1;
        checks++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 ||
            pmem_address !== 32'h0) begin
            errors++;
            $display("FAIL %s_recover: got rd/wr/ir/dr %b%b%b%b addr %h expected 0000 0",
                     tag, pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'hDEAD_0000;
        tick();
        tick();
        checks++;
        if ({pmem_read, pmem_write, i_pmem_resp, d_pmem_resp} !== 4'b0000 ||
            pmem_address !== 32'h0 || pmem_wdata !== 256'h0) begin
            errors++;
            $display("FAIL reset: got rd/wr/ir/dr %b%b%b%b addr %h expected 0000 0",
                     pmem_read, pmem_write, i_pmem_resp, d_pmem_resp, pmem_address);
        end
        i_pmem_read = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_i_read();
        int cyc;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_1000;
        push_grant(1'b1, 1'b0, 32'h0000_1000, 256'h0);
        #1;
        checks++;
        if (pmem_read !== 1'b0) begin
            errors++;
            $display("FAIL i_same_cycle: got pmem_read %b expected 0", pmem_read);
        end
        tick();
        wait_strobe(cyc, "i_read");
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL i_latency: got %0d extra cycles expected 0", cyc);
        end
        check_grant("i_read");
        respond(1'b0, 5, {32{8'hA5}}, "i_read");
        tick();
    endtask

    task automatic test_d_write();
        int cyc;
        d_pmem_write = 1'b1;
        d_pmem_address = 32'h0000_2040;
        d_pmem_wdata = {16{16'h1234}};
        push_grant(1'b0, 1'b1, 32'h0000_2040, {16{16'h1234}});
        tick();
        wait_strobe(cyc, "d_write");
        check_grant("d_write");
        respond(1'b1, 3, {8{32'hCAFE_F00D}}, "d_write");
        tick();
    endtask

    task automatic test_alternation();
        int cyc;
        // Fresh reset so the first tie starts from last_d = 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_3000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_4000;
        d_pmem_wdata = {8{32'h1111_2222}};
        push_grant(1'b1, 1'b0, 32'h0000_4000, {8{32'h1111_2222}});
        push_grant(1'b1, 1'b0, 32'h0000_3000, 256'h0);
        tick();
        wait_strobe(cyc, "tie1_d");
        check_grant("tie1_d");
        respond(1'b1, 2, {8{32'h0D0D_0D0D}}, "tie1_d");
        wait_strobe(cyc, "tie1_i");
        check_grant("tie1_i");
        respond(1'b0, 2, {8{32'h0101_0101}}, "tie1_i");
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_5000;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_6000;
        push_grant(1'b1, 1'b0, 32'h0000_6000, {8{32'h1111_2222}});
        push_grant(1'b1, 1'b0, 32'h0000_5000, 256'h0);
        tick();
        wait_strobe(cyc, "tie2_d");
        check_grant("tie2_d");
        respond(1'b1, 1, {8{32'h2D2D_2D2D}}, "tie2_d");
        wait_strobe(cyc, "tie2_i");
        check_grant("tie2_i");
        respond(1'b0, 1, {8{32'h2121_2121}}, "tie2_i");
        tick();
    endtask

    task automatic test_wait_during_d();
        int cyc;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_7000;
        d_pmem_wdata = {8{32'h7777_0000}};
        push_grant(1'b1, 1'b0, 32'h0000_7000, {8{32'h7777_0000}});
        tick();
        wait_strobe(cyc, "long_d");
        check_grant("long_d");
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_8000;
        push_grant(1'b1, 1'b0, 32'h0000_8000, 256'h0);
        respond(1'b1, 20, {8{32'h5A5A_5A5A}}, "long_d");
        wait_strobe(cyc, "waiting_i");
        checks++;
        if (cyc != 2) begin
            errors++;
            $display("FAIL waiting_i_spacing: got %0d cycles after recover expected 2", cyc);
        end
        check_grant("waiting_i");
        respond(1'b0, 0, {8{32'h8888_8888}}, "waiting_i");
        tick();
    endtask

    task automatic test_reset_mid_grant();
        int cyc;
        d_pmem_read = 1'b1;
        d_pmem_address = 32'h0000_9000;
        d_pmem_wdata = 256'h0;
        push_grant(1'b1, 1'b0, 32'h0000_9000, 256'h0);
        tick();
        wait_strobe(cyc, "rst_mid");
        check_grant("rst_mid");
        tick();
        tick();
        rst = 1'b1;
        d_pmem_read = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++;
            $display("FAIL rst_mid_strobe: got rd/wr %b%b expected 00", pmem_read, pmem_write);
        end
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp} !== 2'b00) begin
            errors++;
            $display("FAIL rst_late_resp: got i/d %b%b expected 00", i_pmem_resp, d_pmem_resp);
        end
        tick();
        pmem_resp = 1'b0;
        #1;
        checks++;
        if ({pmem_read, pmem_write} !== 2'b00) begin
            errors++;
            $display("FAIL rst_late_state: got rd/wr %b%b expected 00", pmem_read, pmem_write);
        end
        tick();
    endtask

    task automatic test_stray_resp();
        int cyc;
        pmem_resp = 1'b1;
        #1;
        checks++;
        if ({i_pmem_resp, d_pmem_resp, pmem_read, pmem_write} !== 4'b0000) begin
            errors++;
            $display("FAIL stray_resp: got ir/dr/rd/wr %b%b%b%b expected 0000",
                     i_pmem_resp, d_pmem_resp, pmem_read, pmem_write);
        end
        tick();
        pmem_resp = 1'b0;
        // Still IDLE: a new I request must be granted on the very next edge.
        i_pmem_read = 1'b1;
        i_pmem_address = 32'h0000_A000;
        push_grant(1'b1, 1'b0, 32'h0000_A000, 256'h0);
        tick();
        wait_strobe(cyc, "stray");
        checks++;
        if (cyc != 0) begin
            errors++;
            $display("FAIL stray_idle_latency: got %0d extra cycles expected 0", cyc);
        end
        check_grant("stray");
        respond(1'b0, 1, {8{32'hABCD_EF01}}, "stray");
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_i_read();
        test_d_write();
        test_alternation();
        test_wait_during_d();
        test_reset_mid_grant();
        test_stray_resp();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending grants expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
